// File: rtl/vga_pkg.sv
// Shared timing defaults and frame-buffer geometry for the VGA picture display.
package vga_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam int unsigned V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int unsigned IMG_W_DEF  = 480;
    localparam int unsigned IMG_H_DEF  = 270;
    localparam int unsigned IMG_X0_DEF = 80;
    localparam int unsigned IMG_Y0_DEF = 105;

    localparam int unsigned FB_DEPTH = 129600;
    localparam int unsigned ADDR_W   = 17;

    // Wide enough for any counter / coordinate used here.
    localparam int unsigned CNT_W = 12;

    localparam logic [23:0] BG_COLOR_DEF = 24'h000000;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel tick divider, horizontal/vertical counters and sync/active decode.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             tick,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active,
    output logic             hs_on,
    output logic             vs_on,
    output logic             frame_wrap,
    output logic             frame_start
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] h_q;
    logic [CNT_W-1:0] v_q;
    logic             h_last;
    logic             v_last;
    logic             frame_start_q;

    assign tick       = (div_q == DIV_LAST);
    assign h_last     = (h_q == H_LAST);
    assign v_last     = (v_q == V_LAST);
    assign frame_wrap = tick && h_last && v_last;

    assign h_cnt       = h_q;
    assign v_cnt       = v_q;
    assign active      = (h_q < H_ACT) && (v_q < V_ACT);
    assign hs_on       = (h_q >= HS_BEG) && (h_q < HS_END);
    assign vs_on       = (v_q >= VS_BEG) && (v_q < VS_END);
    assign frame_start = frame_start_q;

    // Clock divider producing one pixel tick every CLK_DIV clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Raster position counters, advanced once per pixel tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else if (tick) begin
            if (h_last) begin
                h_q <= '0;
                v_q <= v_last ? '0 : v_q + CNT_W'(1);
            end else begin
                h_q <= h_q + CNT_W'(1);
            end
        end
    end

    // One-clock pulse in the clock where the counters have just wrapped to (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_wrap;
        end
    end

endmodule

// File: rtl/vga_pic_display.sv
// VGA display stage: centres the loaded picture on a 640x480 raster.
module vga_pic_display
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned IMG_W    = IMG_W_DEF,
    parameter int unsigned IMG_H    = IMG_H_DEF,
    parameter int unsigned IMG_X0   = IMG_X0_DEF,
    parameter int unsigned IMG_Y0   = IMG_Y0_DEF,
    parameter logic [23:0] BG_COLOR = BG_COLOR_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pic_done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [23:0]       rd_data,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic [23:0]       rgb,
    output logic              frame_start
);

    localparam logic [CNT_W-1:0]  X_BEG     = CNT_W'(IMG_X0);
    localparam logic [CNT_W-1:0]  X_END     = CNT_W'(IMG_X0 + IMG_W);
    localparam logic [CNT_W-1:0]  Y_BEG     = CNT_W'(IMG_Y0);
    localparam logic [CNT_W-1:0]  Y_END     = CNT_W'(IMG_Y0 + IMG_H);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_W * IMG_H - 1);

    logic             tick;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             active;
    logic             hs_on;
    logic             vs_on;
    logic             frame_wrap;
    logic             in_win;

    logic [ADDR_W-1:0] addr_q;
    logic              show_q;
    logic              hsync_q;
    logic              vsync_q;
    logic              de_q;
    logic [23:0]       rgb_q;
    logic [23:0]       rgb_d;

    vga_timing_gen #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .active      (active),
        .hs_on       (hs_on),
        .vs_on       (vs_on),
        .frame_wrap  (frame_wrap),
        .frame_start (frame_start)
    );

    assign in_win = (h_cnt >= X_BEG) && (h_cnt < X_END) && (v_cnt >= Y_BEG) && (v_cnt < Y_END);

    assign rd_addr = addr_q;
    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign de      = de_q;
    assign rgb     = rgb_q;

    // Address tracks the current raster position; the increment when leaving a window
    // pixel prepares the next one, and the last pixel of the picture wraps back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if (frame_wrap) begin
            addr_q <= '0;
        end else if (tick && in_win) begin
            addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
        end
    end

    // Picture-valid flag latched once per frame so a mid-frame change never tears the image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            show_q <= 1'b0;
        end else if (frame_wrap) begin
            show_q <= pic_done;
        end
    end

    // Colour for the pixel being left on this tick; rd_data has settled by now.
    always_comb begin
        rgb_d = '0;
        if (active) begin
            rgb_d = (in_win && show_q) ? rd_data : BG_COLOR;
        end
    end

    // Output stage, one tick behind the counter position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            rgb_q   <= '0;
        end else if (tick) begin
            hsync_q <= ~hs_on;
            vsync_q <= ~vs_on;
            de_q    <= active;
            rgb_q   <= rgb_d;
        end
    end

endmodule

// File: tb/tb_vga_pic_display.sv
// Self-checking bench for vga_pic_display on a scaled-down raster.
module tb_vga_pic_display;
    import vga_pkg::*;

    localparam int CD = 2;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
    localparam int VA = 12, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
    localparam int IW = 6, IH = 4, X0 = 5, Y0 = 4;
    localparam int FT = HT * VT;
    localparam int DEPTH = IW * IH;
    localparam logic [23:0] BG = 24'h5AA53C;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [16:0] addr;
        logic [23:0] rgb;
    } obs_t;

    localparam obs_t RST_OBS = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0, addr: 17'd0, rgb: 24'd0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pic_done = 1'b0;
    logic [16:0] rd_addr;
    logic [23:0] rd_data = '0;
    logic        hsync, vsync, de, frame_start;
    logic [23:0] rgb;
    obs_t        obs;

    logic [23:0] mem [32];
    bit          show_frame [64];
    int          n;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    vga_pic_display #(
        .CLK_DIV  (CD),
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .IMG_W    (IW), .IMG_H (IH), .IMG_X0 (X0), .IMG_Y0 (Y0),
        .BG_COLOR (BG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pic_done    (pic_done),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    assign obs = {hsync, vsync, de, frame_start, rd_addr, rgb};

    // Synchronous frame-buffer RAM, one clock of read latency.
    always @(posedge clk) rd_data <= (rd_addr < 17'(DEPTH)) ? mem[rd_addr[4:0]] : 24'h0;

    // Clock count since reset release, and pic_done as seen at each frame boundary.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n <= 0;
        end else begin
            n <= n + 1;
            if ((n + 1) % CD == 0 && ((n + 1) / CD) % FT == 0 && ((n + 1) / CD) / FT < 64)
                show_frame[6'(((n + 1) / CD) / FT)] <= pic_done;
        end
    end

    // Expected outputs after nn clocks since release. Ticks happen every CD clocks; after
    // tick k the counters sit at raster index k and the outputs describe index k-1.
    function automatic obs_t model(input int nn);
        obs_t e;
        int p, q, h, v, f, hp, vp, rows, cols;
        p  = nn / CD;
        hp = p % HT;
        vp = (p / HT) % VT;
        rows = 0;
        cols = 0;
        if (vp >= Y0 && vp < Y0 + IH) begin
            rows = vp - Y0;
            cols = (hp < X0) ? 0 : (hp >= X0 + IW) ? IW : hp - X0;
        end else if (vp >= Y0 + IH) begin
            rows = IH;
        end
        e.addr = 17'((rows * IW + cols) % DEPTH);
        e.fs   = (nn > 0) && (nn % CD == 0) && (p % FT == 0);
        if (nn < CD) begin
            e.hs  = 1'b1;
            e.vs  = 1'b1;
            e.de  = 1'b0;
            e.rgb = 24'd0;
        end else begin
            q = p - 1;
            h = q % HT;
            v = (q / HT) % VT;
            f = q / FT;
            e.hs = !(h >= HA + HF && h < HA + HF + HS);
            e.vs = !(v >= VA + VF && v < VA + VF + VS);
            e.de = (h < HA) && (v < VA);
            if (!e.de)
                e.rgb = 24'd0;
            else if (h >= X0 && h < X0 + IW && v >= Y0 && v < Y0 + IH && f >= 1 && f < 64
                     && show_frame[6'(f)])
                e.rgb = mem[5'((v - Y0) * IW + (h - X0))];
            else
                e.rgb = BG;
        end
        return e;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) begin
            mem[i] = 24'($urandom);
            if (mem[i] == BG) mem[i] = ~BG;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        obs_t e;
        rst_n = 1'b0;
        pic_done = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (obs !== RST_OBS) begin
                bad++;
                $display("FAIL reset_hold i=%0d got=%h exp=%h", i, obs, RST_OBS);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            e = model(n);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset_release n=%0d got=%h exp=%h", n, obs, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_free_run();
        obs_t e;
        int hs_fall = -1, vs_fall = -1, de_rise = -1, q, h, v, p;
        logic hs_prev = 1'b1, vs_prev = 1'b1, de_prev = 1'b0;
        apply_reset();
        pic_done = 1'b1;
        for (int i = 0; i < 2 * FT * CD + 10; i++) begin
            e = model(n);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL free_run n=%0d got=%h exp=%h", n, obs, e);
            end
            if (hs_prev && !hsync) begin
                if (hs_fall >= 0) begin
                    total++;
                    if (n - hs_fall !== HT * CD) begin
                        bad++;
                        $display("FAIL hsync_period got=%0d exp=%0d", n - hs_fall, HT * CD);
                    end
                end
                hs_fall = n;
            end
            if (!hs_prev && hsync && hs_fall >= 0) begin
                total++;
                if (n - hs_fall !== HS * CD) begin
                    bad++;
                    $display("FAIL hsync_low got=%0d exp=%0d", n - hs_fall, HS * CD);
                end
            end
            if (vs_prev && !vsync) begin
                if (vs_fall >= 0) begin
                    total++;
                    if (n - vs_fall !== FT * CD) begin
                        bad++;
                        $display("FAIL vsync_period got=%0d exp=%0d", n - vs_fall, FT * CD);
                    end
                end
                vs_fall = n;
            end
            if (!vs_prev && vsync && vs_fall >= 0) begin
                total++;
                if (n - vs_fall !== VS * HT * CD) begin
                    bad++;
                    $display("FAIL vsync_low got=%0d exp=%0d", n - vs_fall, VS * HT * CD);
                end
            end
            if (!de_prev && de) de_rise = n;
            if (de_prev && !de && de_rise >= 0) begin
                total++;
                if (n - de_rise !== HA * CD) begin
                    bad++;
                    $display("FAIL de_width got=%0d exp=%0d", n - de_rise, HA * CD);
                end
            end
            // Spot checks on the window corners in the second frame.
            p = n / CD;
            if (p / FT == 1 && p % HT == X0 + IW - 1 && (p / HT) % VT == Y0 + IH - 1) begin
                total++;
                if (rd_addr !== 17'(DEPTH - 1)) begin
                    bad++;
                    $display("FAIL last_addr got=%0d exp=%0d", rd_addr, DEPTH - 1);
                end
            end
            if (n >= CD && n % CD == 0) begin
                q = p - 1;
                h = q % HT;
                v = (q / HT) % VT;
                if (q / FT == 1 && h == X0 && v == Y0) begin
                    total++;
                    if (rgb !== mem[0]) begin
                        bad++;
                        $display("FAIL first_pixel got=%h exp=%h", rgb, mem[0]);
                    end
                end
                if (q / FT == 1 && h == X0 - 1 && v == Y0) begin
                    total++;
                    if (rgb !== BG) begin
                        bad++;
                        $display("FAIL left_of_window got=%h exp=%h", rgb, BG);
                    end
                end
            end
            hs_prev = hsync;
            vs_prev = vsync;
            de_prev = de;
            @(negedge clk);
        end
    endtask

    task automatic test_no_pic();
        obs_t e;
        int de_clks = 0;
        apply_reset();
        pic_done = 1'b0;
        for (int i = 0; i < 2 * FT * CD; i++) begin
            @(negedge clk);
            e = model(n);
            total++;
            if (obs !== e || (de && rgb !== BG)) begin
                bad++;
                $display("FAIL no_pic n=%0d got=%h exp=%h", n, obs, e);
            end
            if (de) de_clks++;
        end
        total++;
        if (de_clks !== 2 * HA * VA * CD) begin
            bad++;
            $display("FAIL no_pic_de_count got=%0d exp=%0d", de_clks, 2 * HA * VA * CD);
        end
    endtask

    task automatic test_pic_rise();
        obs_t e;
        int fs_cnt = 0, img1 = 0, img2 = 0, f;
        apply_reset();
        pic_done = 1'b0;
        for (int i = 0; i < 3 * FT * CD + 2; i++) begin
            @(negedge clk);
            e = model(n);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL pic_rise n=%0d got=%h exp=%h", n, obs, e);
            end
            if (frame_start) fs_cnt++;
            f = (n / CD - 1) / FT;
            if (n % CD == 0 && n >= CD && de && rgb !== BG) begin
                if (f == 1) img1++;
                if (f == 2) img2++;
            end
            if (n == CD * (FT + 8 * HT)) pic_done = 1'b1;
        end
        total++;
        if (fs_cnt !== 3) begin
            bad++;
            $display("FAIL frame_start_count got=%0d exp=3", fs_cnt);
        end
        total++;
        if (img1 !== 0) begin
            bad++;
            $display("FAIL rise_frame_pixels got=%0d exp=0", img1);
        end
        total++;
        if (img2 !== DEPTH) begin
            bad++;
            $display("FAIL next_frame_pixels got=%0d exp=%0d", img2, DEPTH);
        end
    endtask

    task automatic test_reset_mid();
        obs_t e;
        int np;
        apply_reset();
        pic_done = 1'b1;
        np = CD * (FT + $urandom_range(1, VT - 1) * HT + $urandom_range(1, HT - 1));
        for (int i = 0; i < np + 4 && n < np; i++) begin
            @(negedge clk);
            e = model(n);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL pre_reset n=%0d got=%h exp=%h", n, obs, e);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs !== RST_OBS) begin
            bad++;
            $display("FAIL async_reset got=%h exp=%h", obs, RST_OBS);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (obs !== RST_OBS) begin
                bad++;
                $display("FAIL mid_reset_hold got=%h exp=%h", obs, RST_OBS);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < FT * CD + 20; i++) begin
            e = model(n);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL after_reset n=%0d got=%h exp=%h", n, obs, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        obs_t e;
        apply_reset();
        pic_done = 1'($urandom);
        for (int i = 0; i < 4 * FT * CD + 4; i++) begin
            @(negedge clk);
            e = model(n);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL back_to_back n=%0d got=%h exp=%h", n, obs, e);
            end
            if ($urandom_range(0, 299) == 0) pic_done = ~pic_done;
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_no_pic();
        test_pic_rise();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
